truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer_pkg.sv | 22 ++
 rtl/truth_table_sequencer_if.sv | 29 ++
 rtl/truth_table_sequencer_settle_timer.sv | 38 +++
 rtl/truth_table_sequencer.sv | 156 +++++++++++++++
 tb/tb_truth_table_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants and state encoding for the truth-table sweep engine.
package truth_table_sequencer_pkg;

    localparam int NUM_VEC = 16;   // number of input vectors swept
    localparam int VEC_W   = 4;    // width of {a,b,c,d}
    localparam int OUT_W   = 3;    // width of {x,y,z}
    localparam int CNT_W   = 5;    // ones-counters must hold 0..16
    localparam int TMR_W   = 4;    // settle counter width (SETTLE up to 15)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Add a single bit to a ones-counter without width warnings.
    function automatic logic [CNT_W-1:0] add_bit(input logic [CNT_W-1:0] c, input logic b);
        return c + CNT_W'(b);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bundle of control, datapath-under-test and result-readback signals.
interface truth_table_sequencer_if;
    import truth_table_sequencer_pkg::*;

    logic             start;
    logic             abort;
    logic [OUT_W-1:0] xyz;
    logic [VEC_W-1:0] abcd;
    logic             busy;
    logic             done;
    logic [VEC_W-1:0] rd_addr;
    logic [OUT_W-1:0] rd_data;
    logic [CNT_W-1:0] cnt_x;
    logic [CNT_W-1:0] cnt_y;
    logic [CNT_W-1:0] cnt_z;

    // Environment side: requests sweeps, feeds back the datapath outputs, reads results.
    modport master (
        output start, abort, xyz, rd_addr,
        input  abcd, busy, done, rd_data, cnt_x, cnt_y, cnt_z
    );

    // Sequencer side.
    modport slave (
        input  start, abort, xyz, rd_addr,
        output abcd, busy, done, rd_data, cnt_x, cnt_y, cnt_z
    );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts cycles a vector has been held; tc flags the last settle cycle.
module settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // Clear dominates; otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TMR_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = enable && (count_q == TMR_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps {a,b,c,d} through all 16 values, holds each for SETTLE cycles,
// then records the datapath response {x,y,z} and keeps per-output ones counts.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] abcd_q, abcd_d;
    logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
    logic [CNT_W-1:0] cnt_y_q, cnt_y_d;
    logic [CNT_W-1:0] cnt_z_q, cnt_z_d;
    logic [OUT_W-1:0] table_q [NUM_VEC];
    logic [OUT_W-1:0] table_d [NUM_VEC];

    logic go;          // accepted sweep request (abort wins over start)
    logic last_vec;    // current vector is the final one; abcd must not wrap
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_tc;
    logic sample_en;   // SAMPLE cycle that actually commits (not aborted)
    logic busy_o;
    logic done_o;

    assign go         = bus.start && !bus.abort;
    assign last_vec   = (abcd_q == VEC_W'(NUM_VEC - 1));
    assign tmr_enable = (state_q == ST_WAIT);
    assign tmr_clear  = !tmr_enable;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .tc     (tmr_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort returns a running sweep to IDLE without a done pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (go) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.abort)   state_d = ST_IDLE;
                else if (tmr_tc) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort)     state_d = ST_IDLE;
                else if (last_vec) state_d = ST_DONE;
                else               state_d = ST_WAIT;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy_o    = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
        done_o    = (state_q == ST_DONE);
        sample_en = (state_q == ST_SAMPLE) && !bus.abort;
    end

    // Vector and counter updates.
    always_comb begin
        abcd_d  = abcd_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        cnt_z_d = cnt_z_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    abcd_d  = '0;
                    cnt_x_d = '0;
                    cnt_y_d = '0;
                    cnt_z_d = '0;
                end
            end
            ST_WAIT: begin
                if (bus.abort) abcd_d = '0;
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    abcd_d = '0;
                end else begin
                    cnt_x_d = add_bit(cnt_x_q, bus.xyz[2]);
                    cnt_y_d = add_bit(cnt_y_q, bus.xyz[1]);
                    cnt_z_d = add_bit(cnt_z_q, bus.xyz[0]);
                    if (!last_vec) abcd_d = abcd_q + VEC_W'(1);
                end
            end
            ST_DONE:   abcd_d = '0;
            default:   abcd_d = '0;
        endcase
    end

    // Vector and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            abcd_q  <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            cnt_z_q <= '0;
        end else begin
            abcd_q  <= abcd_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            cnt_z_q <= cnt_z_d;
        end
    end

    // Result table: flops rather than RAM so reset can clear every entry and reads stay combinational.
    generate
        for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_table
            // Entry captures xyz only on a committed SAMPLE of its own vector.
            always_comb begin
                table_d[gi] = table_q[gi];
                if (sample_en && (abcd_q == VEC_W'(gi))) table_d[gi] = bus.xyz;
            end

            // Entry register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    table_q[gi] <= '0;
                end else begin
                    table_q[gi] <= table_d[gi];
                end
            end
        end
    endgenerate

    assign bus.abcd    = abcd_q;
    assign bus.busy    = busy_o;
    assign bus.done    = done_o;
    assign bus.cnt_x   = cnt_x_q;
    assign bus.cnt_y   = cnt_y_q;
    assign bus.cnt_z   = cnt_z_q;
    assign bus.rd_data = table_q[bus.rd_addr];

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: timeline-based reference model plus directed and random stimulus.
module tb_truth_table_sequencer;
    import truth_table_sequencer_pkg::*;

    localparam int S = 2;
    localparam int T = 16 * (S + 1);   // cycles from start-sampling edge to done

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       start0  = 1'b0;
    logic       abort0  = 1'b0;
    logic [3:0] rd_addr0 = 4'd0;
    logic       start1  = 1'b0;
    logic       start15 = 1'b0;
    logic [2:0] func_tab [16];

    truth_table_sequencer_if bus0 ();
    truth_table_sequencer_if bus1 ();
    truth_table_sequencer_if bus15 ();

    assign bus0.start   = start0;
    assign bus0.abort   = abort0;
    assign bus0.rd_addr = rd_addr0;
    assign bus0.xyz     = func_tab[bus0.abcd];

    assign bus1.start   = start1;
    assign bus1.abort   = 1'b0;
    assign bus1.rd_addr = 4'd0;
    assign bus1.xyz     = bus1.abcd[2:0];

    assign bus15.start   = start15;
    assign bus15.abort   = 1'b0;
    assign bus15.rd_addr = 4'd0;
    assign bus15.xyz     = bus15.abcd[2:0];

    truth_table_sequencer #(.SETTLE(S))  dut0  (.clk(clk), .rst(rst), .bus(bus0));
    truth_table_sequencer #(.SETTLE(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    truth_table_sequencer #(.SETTLE(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: a sweep is a timeline m_t = cycles since the start edge ----
    int         m_t = -1;          // -1 means idle
    int         m_v;
    logic [2:0] m_tab [16];
    int         m_cnt [3];         // index 2 = x, 1 = y, 0 = z
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1;
            for (int i = 0; i < 16; i++) m_tab[i] = 3'd0;
            for (int b = 0; b < 3; b++) m_cnt[b] = 0;
        end else if (m_t < 0) begin
            if (start0 && !abort0) begin
                m_t = 0;
                for (int b = 0; b < 3; b++) m_cnt[b] = 0;
            end
        end else if (m_t == T) begin
            m_t = -1;
        end else if (abort0) begin
            m_t = -1;
        end else begin
            if (m_t % (S + 1) == S) begin
                m_v = m_t / (S + 1);
                m_tab[m_v] = func_tab[m_v];
                for (int b = 0; b < 3; b++) m_cnt[b] += int'(func_tab[m_v][b]);
            end
            m_t++;
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int e_busy, e_done, e_abcd;
            e_busy = (m_t >= 0 && m_t < T) ? 1 : 0;
            e_done = (m_t == T) ? 1 : 0;
            e_abcd = e_busy ? m_t / (S + 1) : (e_done ? 15 : 0);
            chk("busy",    int'(bus0.busy),    e_busy);
            chk("done",    int'(bus0.done),    e_done);
            chk("abcd",    int'(bus0.abcd),    e_abcd);
            chk("cnt_x",   int'(bus0.cnt_x),   m_cnt[2]);
            chk("cnt_y",   int'(bus0.cnt_y),   m_cnt[1]);
            chk("cnt_z",   int'(bus0.cnt_z),   m_cnt[0]);
            chk("rd_data", int'(bus0.rd_data), int'(m_tab[rd_addr0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ref_func();
        logic [3:0] v4;
        for (int i = 0; i < 16; i++) begin
            v4 = 4'(i);
            func_tab[i] = {v4[3] & v4[2], v4[1] | v4[0], v4[3] ^ v4[0]};
        end
    endtask

    task automatic set_rand_func();
        for (int i = 0; i < 16; i++) func_tab[i] = 3'($urandom);
    endtask

    // Start a sweep and measure the edge count until done; optionally re-pulse start mid-sweep.
    task automatic timed_sweep(input string name, input bit repulse);
        int k;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        while (k < 400) begin
            tick();
            k++;
            if (bus0.done) break;
            if (repulse) start0 = (k >= 5 && k < 9);
        end
        start0 = 1'b0;
        chk(name, k, T);
    endtask

    // Read every table entry and compare to the model.
    task automatic scan_table(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_addr0 = 4'(i);
            #1;
            chk(name, int'(bus0.rd_data), int'(m_tab[i]));
            tick();
        end
    endtask

    // Sweep an auxiliary instance and check per-cycle vector holding and done timing.
    task automatic aux_sweep(input int s);
        int tt, errs, a, bz, dn;
        tt = 16 * (s + 1);
        errs = 0;
        if (s == 1) start1 = 1'b1; else start15 = 1'b1;
        tick();
        start1 = 1'b0;
        start15 = 1'b0;
        for (int k = 1; k <= tt; k++) begin
            tick();
            a  = (s == 1) ? int'(bus1.abcd) : int'(bus15.abcd);
            bz = (s == 1) ? int'(bus1.busy) : int'(bus15.busy);
            dn = (s == 1) ? int'(bus1.done) : int'(bus15.done);
            if (k < tt) begin
                if (bz != 1 || dn != 0 || a != k / (s + 1)) errs++;
            end else begin
                chk($sformatf("aux_done_S%0d", s), dn, 1);
            end
        end
        chk($sformatf("aux_hold_S%0d", s), errs, 0);
        tick();
    endtask

    initial begin
        int k, ndone;
        set_ref_func();
        // Reset
        tick();
        chk_en = 1'b1;
        chk("rst_busy",  int'(bus0.busy),  0);
        chk("rst_done",  int'(bus0.done),  0);
        chk("rst_cnt_x", int'(bus0.cnt_x), 0);
        rst = 1'b0;
        tick();

        // Known-function sweep: x=a&b, y=c|d, z=a^d
        timed_sweep("done_lat", 1'b0);
        tick();
        chk("ref_cnt_x", int'(bus0.cnt_x), 4);
        chk("ref_cnt_y", int'(bus0.cnt_y), 12);
        chk("ref_cnt_z", int'(bus0.cnt_z), 8);
        chk("idle_abcd", int'(bus0.abcd),  0);
        rd_addr0 = 4'd13; #1; chk("ref_tab13", int'(bus0.rd_data), 6);
        rd_addr0 = 4'd0;  #1; chk("ref_tab0",  int'(bus0.rd_data), 0);
        rd_addr0 = 4'd8;  #1; chk("ref_tab8",  int'(bus0.rd_data), 1);
        tick();

        // Start re-pulsed while busy must not restart the sweep
        set_rand_func();
        timed_sweep("done_lat_repulse", 1'b1);
        tick();
        scan_table("tab_after_repulse");

        // Start and abort together while idle
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        chk("sa_busy", int'(bus0.busy), 0);
        chk("sa_abcd", int'(bus0.abcd), 0);
        tick();
        chk("sa_busy2", int'(bus0.busy), 0);
        start0 = 1'b0;
        abort0 = 1'b0;
        tick();

        // Abort partway through a sweep
        set_rand_func();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (9) tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("abort_busy", int'(bus0.busy), 0);
        chk("abort_abcd", int'(bus0.abcd), 0);
        ndone = 0;
        repeat (60) begin
            tick();
            if (bus0.done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        scan_table("tab_after_abort");

        // Reset during SAMPLE of vector 7
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        while (m_t != 7 * (S + 1) + S && k < 200) begin
            tick();
            k++;
        end
        chk("pre_rst_abcd", int'(bus0.abcd), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy",  int'(bus0.busy),  0);
        chk("mrst_cnt_y", int'(bus0.cnt_y), 0);
        chk("mrst_abcd",  int'(bus0.abcd),  0);
        for (int i = 0; i < 16; i++) begin
            rd_addr0 = 4'(i);
            #1;
            chk("mrst_tab", int'(bus0.rd_data), 0);
            tick();
        end

        // SETTLE extremes on the auxiliary instances
        aux_sweep(1);
        aux_sweep(15);

        // Randomized traffic against the model
        repeat (3000) begin
            tick();
            start0   = ($urandom_range(0, 7) == 0);
            abort0   = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            rd_addr0 = 4'($urandom);
            if (m_t < 0 && $urandom_range(0, 3) == 0) set_rand_func();
        end
        start0 = 1'b0;
        abort0 = 1'b0;
        rst    = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
